one_audio_pack: RTL



---
 rtl/one_audio_pack.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/one_audio_pack.sv
// ---------------------------------------------------------------------------
// one_audio_pack
//
// Captures one stereo I2S stream by oversampling its pins in the 148.5 MHz
// system clock. Each complete left/right sample pair is packed into one
// tagged 64-bit word and presented through a single-entry valid/ready
// output register.
//
// Ports
//   i_clk148p5M   system clock, the only clock in the block
//   i_rst_n       synchronous, active-low reset
//   i_i2s_sclk    I2S bit clock (asynchronous, at most 1/6 of i_clk148p5M)
//   i_i2s_rlclk   I2S word clock, 0 = left slot, 1 = right slot
//   i_i2s_data    I2S serial data, MSB first, one SCLK after the slot edge
//   o_valid       o_data holds a packed frame
//   o_data        {SYNC_TAG, seq[7:0], left[23:0], right[23:0]}
//   i_ready       downstream takes o_data when o_valid & i_ready
//   o_overflow    one-cycle pulse when a completed frame had to be dropped
// ---------------------------------------------------------------------------
module one_audio_pack #(
    parameter int         SAMPLE_BITS = 24,
    parameter int         SLOT_BITS   = 32,
    parameter logic [7:0] SYNC_TAG    = 8'hA5
) (
    input  logic        i_clk148p5M,
    input  logic        i_rst_n,
    input  logic        i_i2s_sclk,
    input  logic        i_i2s_rlclk,
    input  logic        i_i2s_data,
    output logic        o_valid,
    output logic [63:0] o_data,
    input  logic        i_ready,
    output logic        o_overflow
);

    localparam int               CNT_W      = $clog2(SLOT_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_BITS);

    // Pin bundle: [2] = sclk, [1] = rlclk, [0] = data. All three go through
    // identical two-flop synchronizers so they stay aligned to each other.
    logic [2:0] pin_vec;
    logic [2:0] s1_reg;
    logic [2:0] s2_reg;
    logic       sclk_s3_reg;

    assign pin_vec = {i_i2s_sclk, i_i2s_rlclk, i_i2s_data};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            always_ff @(posedge i_clk148p5M) begin
                if (!i_rst_n) begin
                    s1_reg[gi] <= 1'b0;
                    s2_reg[gi] <= 1'b0;
                end else begin
                    s1_reg[gi] <= pin_vec[gi];
                    s2_reg[gi] <= s1_reg[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk148p5M) begin
        if (!i_rst_n) begin
            sclk_s3_reg <= 1'b0;
        end else begin
            sclk_s3_reg <= s2_reg[2];
        end
    end

    // Capture state
    logic                   rl_prev_reg;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic [CNT_W-1:0]       bit_cnt_next;
    logic [CNT_W-1:0]       cnt_inc;
    logic [SAMPLE_BITS-1:0] shreg_reg;
    logic [SAMPLE_BITS-1:0] shreg_next;
    logic [SAMPLE_BITS-1:0] left_hold_reg;
    logic                   left_ok_reg;

    // Output state
    logic                   o_valid_reg;
    logic [63:0]            o_data_reg;
    logic                   o_overflow_reg;
    logic [7:0]             seq_reg;

    logic sclk_rise;
    logic rl_s2;
    logic data_s2;
    logic rl_change;
    logic shift_en;
    logic chan_done;
    logic left_done;
    logic right_done;
    logic frame_fire;
    logic can_load;

    assign sclk_rise = s2_reg[2] & ~sclk_s3_reg;
    assign rl_s2     = s2_reg[1];
    assign data_s2   = s2_reg[0];
    assign rl_change = (rl_s2 != rl_prev_reg);

    always_comb begin
        cnt_inc      = (bit_cnt_reg == CNT_MAX) ? bit_cnt_reg : bit_cnt_reg + CNT_W'(1);
        // The bit on the word-clock edge is the tail of the previous slot,
        // so a slot restart clears the count without shifting.
        bit_cnt_next = rl_change ? '0 : cnt_inc;
        shift_en     = sclk_rise && !rl_change && (cnt_inc != '0) && (cnt_inc <= CNT_SAMPLE);
        shreg_next   = {shreg_reg[SAMPLE_BITS-2:0], data_s2};
        chan_done    = shift_en && (cnt_inc == CNT_SAMPLE);
        left_done    = chan_done && !rl_s2;
        right_done   = chan_done && rl_s2;
        // A right sample only forms a frame if a full left sample preceded
        // it; otherwise it is the tail of a stream we joined part-way.
        frame_fire   = right_done && left_ok_reg;
        can_load     = !o_valid_reg || i_ready;
    end

    always_ff @(posedge i_clk148p5M) begin
        if (!i_rst_n) begin
            rl_prev_reg   <= 1'b0;
            bit_cnt_reg   <= CNT_MAX;
            shreg_reg     <= '0;
            left_hold_reg <= '0;
            left_ok_reg   <= 1'b0;
        end else if (sclk_rise) begin
            rl_prev_reg <= rl_s2;
            bit_cnt_reg <= bit_cnt_next;
            if (shift_en) begin
                shreg_reg <= shreg_next;
            end
            if (left_done) begin
                left_hold_reg <= shreg_next;
                left_ok_reg   <= 1'b1;
            end
            if (right_done) begin
                left_ok_reg <= 1'b0;
            end
        end
    end

    // Single-entry output register. A frame that completes while the
    // register is full and not being drained is dropped, but seq still
    // advances so the receiver can detect the gap.
    always_ff @(posedge i_clk148p5M) begin
        if (!i_rst_n) begin
            o_valid_reg    <= 1'b0;
            o_data_reg     <= 64'h0;
            o_overflow_reg <= 1'b0;
            seq_reg        <= 8'h00;
        end else begin
            o_overflow_reg <= 1'b0;
            if (frame_fire) begin
                seq_reg <= seq_reg + 8'h01;
                if (can_load) begin
                    o_data_reg  <= {SYNC_TAG, seq_reg, left_hold_reg, shreg_next};
                    o_valid_reg <= 1'b1;
                end else begin
                    o_overflow_reg <= 1'b1;
                end
            end else if (o_valid_reg && i_ready) begin
                o_valid_reg <= 1'b0;
            end
        end
    end

    assign o_valid    = o_valid_reg;
    assign o_data     = o_data_reg;
    assign o_overflow = o_overflow_reg;

endmodule
